hsst_ad_packer: RTL and testbench

//  Downstream consumer of the AD data prefetch FIFO, in the FIFO read-clock domain. Pops 8-bit AD samples
//  (rd_vld/rd_en first-word-fall-through handshake) and frames them into 32-bit HSST TX words with K-char

---
 rtl/hsst_pkt_pkg.sv | 36 +++
 rtl/hsst_ad_word_pack.sv | 46 ++++
 rtl/hsst_ad_packer.sv | 121 ++++++++++++
 tb/tb_hsst_ad_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hsst_pkt_pkg.sv
// Shared K-character constants, word builders and FSM encoding for the AD -> HSST packet framer.
package hsst_pkt_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned KFLG_W = 4;
  localparam int unsigned LEN_W  = 16;

  localparam logic [BYTE_W-1:0] K_COMMA = 8'hBC;
  localparam logic [BYTE_W-1:0] K_SOF   = 8'hFB;
  localparam logic [BYTE_W-1:0] K_EOF   = 8'hFD;
  localparam logic [WORD_W-1:0] IDLE_W  = 32'h505050BC;

  localparam logic [KFLG_W-1:0] K_CTRL = 4'b0001;
  localparam logic [KFLG_W-1:0] K_DATA = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_EOF     = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] d;
    logic [KFLG_W-1:0] k;
  } tx_word_t;

  function automatic tx_word_t sof_word(input logic [LEN_W-1:0] len, input logic [BYTE_W-1:0] seq);
    return '{d: {len, seq, K_SOF}, k: K_CTRL};
  endfunction

  function automatic tx_word_t eof_word(input logic [LEN_W-1:0] csum);
    return '{d: {8'h00, csum, K_EOF}, k: K_CTRL};
  endfunction

endpackage

// File: rtl/hsst_ad_word_pack.sv
// Packs popped bytes into 32-bit lanes (first byte in lane 0) and keeps a running 16-bit byte sum.
module hsst_ad_word_pack
  import hsst_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word,
  output logic              word_done,
  output logic [LEN_W-1:0]  csum
);

  logic [1:0]        byte_cnt;
  logic [BYTE_W-1:0] lane0;
  logic [BYTE_W-1:0] lane1;
  logic [BYTE_W-1:0] lane2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      lane0    <= '0;
      lane1    <= '0;
      lane2    <= '0;
      csum     <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      csum     <= '0;
    end else if (push) begin
      case (byte_cnt)
        2'd0:    lane0 <= din;
        2'd1:    lane1 <= din;
        2'd2:    lane2 <= din;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
      csum     <= csum + LEN_W'(din);
    end
  end

  // Lane 3 is never stored: the fourth byte goes straight into the completed word.
  assign word      = {din, lane2, lane1, lane0};
  assign word_done = push & (byte_cnt == 2'd3);

endmodule

// File: rtl/hsst_ad_packer.sv
// Frames FIFO AD bytes into HSST TX words: SOF, PAYLOAD_WORDS data words, EOF with checksum, comma idles.
module hsst_ad_packer
  import hsst_pkt_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = 256,
  parameter int unsigned MIN_IDLE      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tx_rdy,
  input  logic        fifo_rd_vld,
  input  logic [7:0]  fifo_rd_data,
  output logic        fifo_rd_en,
  output logic [31:0] txd,
  output logic [3:0]  txk,
  output logic        busy,
  output logic        pkt_done,
  output logic        pkt_abort
);

  localparam int unsigned ICNT_W = 8;
  localparam logic [LEN_W-1:0]  PKT_LEN   = LEN_W'(PAYLOAD_WORDS);
  localparam logic [LEN_W-1:0]  LAST_WORD = LEN_W'(PAYLOAD_WORDS - 1);
  localparam logic [ICNT_W-1:0] IDLE_MIN  = ICNT_W'(MIN_IDLE);

  state_t            state;
  logic [LEN_W-1:0]  word_cnt;
  logic [ICNT_W-1:0] idle_cnt;
  logic [BYTE_W-1:0] seq;

  logic              start;
  logic              abort;
  logic              pack_clear;
  logic [WORD_W-1:0] pack_word;
  logic              pack_done;
  logic [LEN_W-1:0]  csum;
  tx_word_t          sof_w;
  tx_word_t          eof_w;

  assign fifo_rd_en = (state == ST_PAYLOAD) & fifo_rd_vld & tx_rdy;
  assign busy       = (state != ST_IDLE);
  assign start      = (state == ST_IDLE) & (idle_cnt >= IDLE_MIN) & en & tx_rdy & fifo_rd_vld;
  assign abort      = (state != ST_IDLE) & ~tx_rdy;
  assign pack_clear = start | abort;
  assign sof_w      = sof_word(PKT_LEN, seq);
  assign eof_w      = eof_word(csum);

  hsst_ad_word_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .push      (fifo_rd_en),
    .din       (fifo_rd_data),
    .word      (pack_word),
    .word_done (pack_done),
    .csum      (csum)
  );

  // Every edge reloads txd/txk; comma idle is the default so stalls and gaps emit fillers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      txd       <= IDLE_W;
      txk       <= K_CTRL;
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      seq       <= '0;
      idle_cnt  <= '0;
      word_cnt  <= '0;
    end else begin
      txd       <= IDLE_W;
      txk       <= K_CTRL;
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            txd      <= sof_w.d;
            txk      <= sof_w.k;
            word_cnt <= '0;
            idle_cnt <= '0;
            state    <= ST_PAYLOAD;
          end else if (idle_cnt < IDLE_MIN) begin
            idle_cnt <= idle_cnt + ICNT_W'(1);
          end
        end
        ST_PAYLOAD: begin
          if (abort) begin
            pkt_abort <= 1'b1;
            idle_cnt  <= '0;
            state     <= ST_IDLE;
          end else if (pack_done) begin
            txd <= pack_word;
            txk <= K_DATA;
            if (word_cnt == LAST_WORD) begin
              state <= ST_EOF;
            end else begin
              word_cnt <= word_cnt + LEN_W'(1);
            end
          end
        end
        ST_EOF: begin
          if (abort) begin
            pkt_abort <= 1'b1;
            idle_cnt  <= '0;
            state     <= ST_IDLE;
          end else begin
            txd      <= eof_w.d;
            txk      <= eof_w.k;
            pkt_done <= 1'b1;
            seq      <= seq + BYTE_W'(1);
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsst_ad_packer.sv
// Directed bench for hsst_ad_packer with PAYLOAD_WORDS=2, MIN_IDLE=4 and a small FWFT FIFO model.
module tb_hsst_ad_packer;
  import hsst_pkt_pkg::*;

  localparam int PW = 2;
  localparam int MI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        tx_rdy;
  logic        fifo_rd_vld;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic [31:0] txd;
  logic [3:0]  txk;
  logic        busy;
  logic        pkt_done;
  logic        pkt_abort;

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       vld_gate = 1'b1;

  always #5 clk = ~clk;

  assign fifo_rd_vld  = vld_gate && (rd_ptr != wr_ptr);
  assign fifo_rd_data = mem[rd_ptr[11:0]];

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_rd_vld) rd_ptr <= rd_ptr + 1;
  end

  hsst_ad_packer #(.PAYLOAD_WORDS(PW), .MIN_IDLE(MI)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tx_rdy       (tx_rdy),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .txd          (txd),
    .txk          (txk),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .pkt_abort    (pkt_abort)
  );

  task automatic push8(input int base);
    for (int i = 0; i < 8; i++) begin
      mem[wr_ptr[11:0]] = 8'(base + i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Skips comma idles; returns the next non-idle word and how many idles preceded it.
  task automatic next_word(output logic [31:0] d, output logic [3:0] k, output logic dn, output int idles);
    int  n;
    logic found;
    n = 0; idles = 0; found = 1'b0;
    d = IDLE_W; k = 4'b0001; dn = 1'b0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (txd === IDLE_W && txk === 4'b0001) idles++;
      else begin
        d = txd; k = txk; dn = pkt_done; found = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; tx_rdy = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (txd !== 32'h505050BC) $display("FAIL rst_txd: got %h want 505050bc", txd); else n_pass++;
    n_chk++; if (txk !== 4'b0001) $display("FAIL rst_txk: got %b want 0001", txk); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
    n_chk++; if (pkt_done !== 1'b0 || pkt_abort !== 1'b0)
      $display("FAIL rst_pulses: got done=%b abort=%b want 0 0", pkt_done, pkt_abort); else n_pass++;
  endtask

  task automatic test_basic;
    logic [31:0] d; logic [3:0] k; logic dn; int idl;
    push8(1);
    en = 1'b1; tx_rdy = 1'b1;
    rst = 1'b0;
    next_word(d, k, dn, idl);
    n_chk++; if (idl !== 4) $display("FAIL basic_idles: got %0d want 4", idl); else n_pass++;
    n_chk++; if (d !== 32'h000200FB || k !== 4'b0001)
      $display("FAIL basic_sof: got %h/%b want 000200fb/0001", d, k); else n_pass++;
    n_chk++; if (fifo_rd_en !== 1'b1) $display("FAIL basic_rd_en: got %b want 1", fifo_rd_en); else n_pass++;
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h04030201 || k !== 4'b0000 || idl !== 3)
      $display("FAIL basic_data0: got %h/%b idles %0d want 04030201/0000 idles 3", d, k, idl); else n_pass++;
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h08070605 || k !== 4'b0000 || idl !== 3)
      $display("FAIL basic_data1: got %h/%b idles %0d want 08070605/0000 idles 3", d, k, idl); else n_pass++;
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h000024FD || k !== 4'b0001 || dn !== 1'b1 || idl !== 0)
      $display("FAIL basic_eof: got %h/%b done %b idles %0d want 000024fd/0001 done 1 idles 0", d, k, dn, idl);
    else n_pass++;
    @(negedge clk);
    n_chk++; if (txd !== IDLE_W || pkt_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_after: got %h done %b busy %b want 505050bc 0 0", txd, pkt_done, busy); else n_pass++;
  endtask

  task automatic test_stall;
    logic [31:0] d; logic [3:0] k; logic dn; int idl; int base; int bad;
    base = rd_ptr; bad = 0;
    push8(1);
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h000201FB) $display("FAIL stall_sof: got %h want 000201fb", d); else n_pass++;
    repeat (2) @(negedge clk);
    vld_gate = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || txd !== IDLE_W) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL stall_fill: got %0d bad cycles want 0", bad); else n_pass++;
    n_chk++; if (rd_ptr - base !== 2) $display("FAIL stall_pops: got %0d want 2", rd_ptr - base); else n_pass++;
    vld_gate = 1'b1;
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h04030201) $display("FAIL stall_data0: got %h want 04030201", d); else n_pass++;
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h08070605) $display("FAIL stall_data1: got %h want 08070605", d); else n_pass++;
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h000024FD || dn !== 1'b1)
      $display("FAIL stall_eof: got %h done %b want 000024fd 1", d, dn); else n_pass++;
  endtask

  task automatic test_abort;
    logic [31:0] d; logic [3:0] k; logic dn; int idl; int base;
    base = rd_ptr;
    push8(1);
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h000202FB) $display("FAIL abort_sof: got %h want 000202fb", d); else n_pass++;
    repeat (5) @(negedge clk);
    tx_rdy = 1'b0;
    #1;
    n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL abort_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (pkt_abort !== 1'b1 || txd !== IDLE_W || busy !== 1'b0)
      $display("FAIL abort_pulse: got abort %b txd %h busy %b want 1 505050bc 0", pkt_abort, txd, busy); else n_pass++;
    n_chk++; if (rd_ptr - base !== 5) $display("FAIL abort_pops: got %0d want 5", rd_ptr - base); else n_pass++;
    wr_ptr = rd_ptr;
    @(negedge clk);
    n_chk++; if (pkt_abort !== 1'b0) $display("FAIL abort_width: got %b want 0", pkt_abort); else n_pass++;
    tx_rdy = 1'b1;
    push8(1);
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h000202FB || idl !== 3)
      $display("FAIL abort_resof: got %h idles %0d want 000202fb idles 3", d, idl); else n_pass++;
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h04030201) $display("FAIL abort_data0: got %h want 04030201", d); else n_pass++;
    next_word(d, k, dn, idl);
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h000024FD || dn !== 1'b1)
      $display("FAIL abort_eof: got %h done %b want 000024fd 1", d, dn); else n_pass++;
  endtask

  task automatic test_en;
    logic [31:0] d; logic [3:0] k; logic dn; int idl; int bad; int base;
    en = 1'b0; bad = 0; base = rd_ptr;
    push8(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || txd !== IDLE_W) bad++;
    end
    n_chk++; if (bad !== 0 || rd_ptr !== base)
      $display("FAIL en_hold: got %0d bad cycles %0d pops want 0 0", bad, rd_ptr - base); else n_pass++;
    en = 1'b1;
    next_word(d, k, dn, idl);
    en = 1'b0;
    n_chk++; if (d !== 32'h000203FB) $display("FAIL en_sof: got %h want 000203fb", d); else n_pass++;
    next_word(d, k, dn, idl);
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h08070605) $display("FAIL en_data1: got %h want 08070605", d); else n_pass++;
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h000024FD || dn !== 1'b1)
      $display("FAIL en_eof: got %h done %b want 000024fd 1", d, dn); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic [3:0] k; logic dn; int idl;
    en = 1'b1;
    push8(1);
    next_word(d, k, dn, idl);
    n_chk++; if (d !== 32'h000204FB) $display("FAIL rmid_sof: got %h want 000204fb", d); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (txd !== 32'h505050BC || txk !== 4'b0001)
      $display("FAIL rmid_txd: got %h/%b want 505050bc/0001", txd, txk); else n_pass++;
    n_chk++; if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || pkt_abort !== 1'b0)
      $display("FAIL rmid_ctrl: got rd_en %b busy %b abort %b want 0 0 0", fifo_rd_en, busy, pkt_abort);
    else n_pass++;
    wr_ptr = rd_ptr;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic [3:0] k; logic dn; int idl;
    logic [7:0]  b [8];
    logic [15:0] cs;
    en = 1'b1; tx_rdy = 1'b1;
    for (int p = 0; p < 257; p++) begin
      cs = 16'h0000;
      for (int i = 0; i < 8; i++) begin
        b[i] = 8'(p + i);
        cs = cs + 16'(b[i]);
      end
      push8(p);
      next_word(d, k, dn, idl);
      n_chk++; if (d !== {16'h0002, 8'(p), K_SOF} || idl !== MI)
        $display("FAIL b2b_sof[%0d]: got %h idles %0d want %h idles %0d", p, d, idl, {16'h0002, 8'(p), K_SOF}, MI);
      else n_pass++;
      next_word(d, k, dn, idl);
      n_chk++; if (d !== {b[3], b[2], b[1], b[0]})
        $display("FAIL b2b_data0[%0d]: got %h want %h", p, d, {b[3], b[2], b[1], b[0]}); else n_pass++;
      next_word(d, k, dn, idl);
      n_chk++; if (d !== {b[7], b[6], b[5], b[4]})
        $display("FAIL b2b_data1[%0d]: got %h want %h", p, d, {b[7], b[6], b[5], b[4]}); else n_pass++;
      next_word(d, k, dn, idl);
      n_chk++; if (d !== {8'h00, cs, K_EOF} || dn !== 1'b1)
        $display("FAIL b2b_eof[%0d]: got %h done %b want %h done 1", p, d, dn, {8'h00, cs, K_EOF}); else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_abort;
    test_en;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
